dict_imem: RTL and testbench

//  Dictionary-decompressing instruction memory; responder side of the icache refill port (mem_req_valid/ready/addr/rdata).

---
 rtl/dict_imem_pkg.sv | 19 +
 rtl/dict_imem_sram.sv | 25 ++
 rtl/dict_imem.sv | 125 ++++++++++++
 tb/tb_dict_imem.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dict_imem_pkg.sv
// Shared constants for the dictionary-decompressing instruction memory:
// FSM encodings, entry layout and the word returned for out-of-range fetches.
package dict_imem_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_EXPAND = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam int          ENTRY_W       = 33;
  localparam int          DICT_FLAG_BIT = 32;
  localparam logic [31:0] ERR_WORD      = 32'h0010_0073;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dict_imem_sram.sv
// Synchronous-read single-port array with one cycle of read latency.
// The write side is a load port; the instruction memory ties it off.
module dict_imem_sram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dict_imem.sv
// Instruction memory answering icache refills: each slot holds a raw word or a
// dictionary index, expanded to a 32-bit instruction with fixed latency.
module dict_imem
  import dict_imem_pkg::*;
#(
  parameter int IDX_AW    = 10,
  parameter int DICT_AW   = 8,
  parameter int EXTRA_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_err,
  output logic [31:0] stat_raw,
  output logic [31:0] stat_dict
);

  localparam logic [3:0] WAIT_INIT = 4'(EXTRA_LAT);

  // Handshake: mem_valid is held with a stable request until mem_ready, which
  // is a one-cycle strobe; mem_rdata/mem_err are meaningful only with it.
  logic [2:0]         state;
  logic               err_q;
  logic               is_dict_q;
  logic [31:0]        word_q;
  logic [3:0]         wait_cnt;
  logic               addr_oor;
  logic [IDX_AW-1:0]  entry_addr;
  logic [ENTRY_W-1:0] entry_rdata;
  logic [DICT_AW-1:0] dict_addr;
  logic [31:0]        dict_rdata;
  logic               unused_addr_bits;

  assign addr_oor         = |mem_addr[31:IDX_AW+2];
  assign entry_addr       = mem_addr[IDX_AW+1:2];
  assign dict_addr        = entry_rdata[DICT_AW-1:0];
  assign unused_addr_bits = ^mem_addr[1:0];

  dict_imem_sram #(.DEPTH(2**IDX_AW), .WIDTH(ENTRY_W)) entry_mem (
    .clk   (clk),
    .en    (state == S_IDLE),
    .we    (1'b0),
    .addr  (entry_addr),
    .wdata ('0),
    .rdata (entry_rdata)
  );

  dict_imem_sram #(.DEPTH(2**DICT_AW), .WIDTH(32)) dict_mem (
    .clk   (clk),
    .en    (state == S_LOOKUP),
    .we    (1'b0),
    .addr  (dict_addr),
    .wdata ('0),
    .rdata (dict_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      err_q     <= 1'b0;
      is_dict_q <= 1'b0;
      word_q    <= '0;
      wait_cnt  <= '0;
      stat_raw  <= '0;
      stat_dict <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_valid) begin
            err_q <= addr_oor;
            state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (!mem_valid) begin
            state <= S_IDLE;
          end else if (!err_q && entry_rdata[DICT_FLAG_BIT]) begin
            is_dict_q <= 1'b1;
            state     <= S_EXPAND;
          end else begin
            // Errors still pass through LOOKUP so they share the raw latency.
            word_q    <= err_q ? ERR_WORD : entry_rdata[31:0];
            is_dict_q <= 1'b0;
            wait_cnt  <= WAIT_INIT;
            state     <= (EXTRA_LAT > 0) ? S_WAIT : S_RESP;
          end
        end
        S_EXPAND: begin
          if (!mem_valid) begin
            state <= S_IDLE;
          end else begin
            word_q   <= dict_rdata;
            wait_cnt <= WAIT_INIT;
            state    <= (EXTRA_LAT > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (!mem_valid) begin
            state <= S_IDLE;
          end else if (wait_cnt == 4'd1) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (!err_q) begin
            if (is_dict_q) stat_dict <= sat_inc(stat_dict);
            else           stat_raw  <= sat_inc(stat_raw);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_ready = (state == S_RESP);
  assign mem_rdata = mem_ready ? word_q : 32'd0;
  assign mem_err   = mem_ready & err_q;

endmodule

// File: tb/tb_dict_imem.sv
// Directed bench for dict_imem: latency, expansion, errors, aborts, reset,
// saturation and a back-to-back stream against a small reference model.
module tb_dict_imem;
  import dict_imem_pkg::*;

  logic        clk;
  logic        reset;
  logic        valid0, valid4;
  logic [31:0] addr0, addr4;
  logic        ready0, ready4;
  logic [31:0] rdata0, rdata4;
  logic        err0, err4;
  logic [31:0] sraw0, sdict0, sraw4, sdict4;

  int n_checks;
  int n_fail;

  logic [32:0] ref_entry [16];
  logic [31:0] ref_dict  [8];
  logic [31:0] exp_q[$];
  int          exp_lat_q[$];

  dict_imem #(.IDX_AW(10), .DICT_AW(8), .EXTRA_LAT(0)) dut (
    .clk(clk), .reset(reset), .mem_valid(valid0), .mem_addr(addr0),
    .mem_ready(ready0), .mem_rdata(rdata0), .mem_err(err0),
    .stat_raw(sraw0), .stat_dict(sdict0)
  );

  dict_imem #(.IDX_AW(10), .DICT_AW(8), .EXTRA_LAT(4)) dut4 (
    .clk(clk), .reset(reset), .mem_valid(valid4), .mem_addr(addr4),
    .mem_ready(ready4), .mem_rdata(rdata4), .mem_err(err4),
    .stat_raw(sraw4), .stat_dict(sdict4)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Driver: one request on the chosen instance; returns latency in cycles
  // (cycle 0 = request sampled in IDLE, -1 on timeout) and the strobe level
  // one cycle after the response.
  task automatic do_fetch(input int sel, input logic [31:0] a, output int lat,
                          output logic [31:0] rd, output logic er, output logic after);
    logic got;
    got = 1'b0; lat = -1; rd = '0; er = 1'b0; after = 1'b1;
    @(negedge clk);
    if (sel == 0) begin valid0 = 1'b1; addr0 = a; end
    else          begin valid4 = 1'b1; addr4 = a; end
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (sel == 0) addr0 = 32'hFFFF_FFF0;
        else          addr4 = 32'hFFFF_FFF0;
      end
      if ((sel == 0) ? ready0 : ready4) begin
        got = 1'b1;
        lat = c;
        rd  = (sel == 0) ? rdata0 : rdata4;
        er  = (sel == 0) ? err0 : err4;
      end
    end
    valid0 = 1'b0;
    valid4 = 1'b0;
    if (got) begin
      @(negedge clk);
      after = (sel == 0) ? ready0 : ready4;
    end
  endtask

  task automatic load_basic;
    dut.entry_mem.mem[4]  = 33'h0_0000_0513;
    dut.entry_mem.mem[5]  = 33'h1_ABCD_EF03;
    dut.dict_mem.mem[3]   = 32'h0010_0093;
    dut4.entry_mem.mem[4] = 33'h0_0000_0513;
    dut4.entry_mem.mem[5] = 33'h1_ABCD_EF03;
    dut4.dict_mem.mem[3]  = 32'h0010_0093;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready0); end
    n_checks++; if (rdata0 !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rdata0); end
    n_checks++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err0); end
    n_checks++; if (sraw0 !== 32'd0) begin n_fail++; $display("FAIL reset_stat_raw: got %h expected 0", sraw0); end
    n_checks++; if (sdict0 !== 32'd0) begin n_fail++; $display("FAIL reset_stat_dict: got %h expected 0", sdict0); end
    n_checks++; if (dut.state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dut.state); end
  endtask

  task automatic test_raw;
    int lat; logic [31:0] rd; logic er, after;
    do_fetch(0, 32'h10, lat, rd, er, after);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL raw_latency: got %0d expected 2", lat); end
    n_checks++; if (rd !== 32'h0000_0513) begin n_fail++; $display("FAIL raw_rdata: got %h expected 00000513", rd); end
    n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL raw_err: got %b expected 0", er); end
    n_checks++; if (after !== 1'b0) begin n_fail++; $display("FAIL raw_ready_width: got %b expected 0", after); end
    n_checks++; if (sraw0 !== 32'd1) begin n_fail++; $display("FAIL raw_stat_raw: got %h expected 1", sraw0); end
    n_checks++; if (sdict0 !== 32'd0) begin n_fail++; $display("FAIL raw_stat_dict: got %h expected 0", sdict0); end
  endtask

  task automatic test_dict;
    int lat; logic [31:0] rd; logic er, after;
    do_fetch(0, 32'h14, lat, rd, er, after);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL dict_latency: got %0d expected 3", lat); end
    n_checks++; if (rd !== 32'h0010_0093) begin n_fail++; $display("FAIL dict_rdata: got %h expected 00100093", rd); end
    n_checks++; if (after !== 1'b0) begin n_fail++; $display("FAIL dict_ready_width: got %b expected 0", after); end
    n_checks++; if (sdict0 !== 32'd1) begin n_fail++; $display("FAIL dict_stat_dict: got %h expected 1", sdict0); end
    n_checks++; if (sraw0 !== 32'd1) begin n_fail++; $display("FAIL dict_stat_raw: got %h expected 1", sraw0); end
  endtask

  task automatic test_extra_lat;
    int lat; logic [31:0] rd; logic er, after;
    do_fetch(1, 32'h10, lat, rd, er, after);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL lat4_raw_latency: got %0d expected 6", lat); end
    n_checks++; if (rd !== 32'h0000_0513) begin n_fail++; $display("FAIL lat4_raw_rdata: got %h expected 00000513", rd); end
    n_checks++; if (after !== 1'b0) begin n_fail++; $display("FAIL lat4_raw_width: got %b expected 0", after); end
    do_fetch(1, 32'h14, lat, rd, er, after);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL lat4_dict_latency: got %0d expected 7", lat); end
    n_checks++; if (rd !== 32'h0010_0093) begin n_fail++; $display("FAIL lat4_dict_rdata: got %h expected 00100093", rd); end
    n_checks++; if (after !== 1'b0) begin n_fail++; $display("FAIL lat4_dict_width: got %b expected 0", after); end
    n_checks++; if (sraw4 !== 32'd1 || sdict4 !== 32'd1) begin
      n_fail++; $display("FAIL lat4_stats: got raw %h dict %h expected 1 and 1", sraw4, sdict4);
    end
  endtask

  task automatic test_err;
    int lat; logic [31:0] rd; logic er, after;
    do_fetch(0, 32'h0010_0000, lat, rd, er, after);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL err_latency: got %0d expected 2", lat); end
    n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b expected 1", er); end
    n_checks++; if (rd !== 32'h0010_0073) begin n_fail++; $display("FAIL err_rdata: got %h expected 00100073", rd); end
    n_checks++; if (sraw0 !== 32'd1 || sdict0 !== 32'd1) begin
      n_fail++; $display("FAIL err_stats: got raw %h dict %h expected 1 and 1", sraw0, sdict0);
    end
  endtask

  task automatic test_abort;
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    valid0 = 1'b1; addr0 = 32'h10;
    @(negedge clk);
    n_checks++; if (dut.state !== S_LOOKUP) begin n_fail++; $display("FAIL abort_in_lookup: got %0d expected 1", dut.state); end
    valid0 = 1'b0;
    @(negedge clk);
    n_checks++; if (dut.state !== S_IDLE) begin n_fail++; $display("FAIL abort_idle: got %0d expected 0", dut.state); end
    repeat (5) begin
      if (ready0) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got %b expected 0", seen); end
    n_checks++; if (sraw0 !== 32'd1) begin n_fail++; $display("FAIL abort_stat_raw: got %h expected 1", sraw0); end
  endtask

  task automatic test_saturate;
    int lat; logic [31:0] rd; logic er, after;
    @(negedge clk);
    dut.stat_raw = 32'hFFFF_FFFE;
    do_fetch(0, 32'h10, lat, rd, er, after);
    n_checks++; if (sraw0 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_reach: got %h expected ffffffff", sraw0); end
    do_fetch(0, 32'h10, lat, rd, er, after);
    n_checks++; if (sraw0 !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold: got %h expected ffffffff", sraw0); end
    do_fetch(0, 32'h14, lat, rd, er, after);
    n_checks++; if (sdict0 !== 32'd2) begin n_fail++; $display("FAIL sat_dict_counts: got %h expected 2", sdict0); end
  endtask

  task automatic test_reset_mid;
    int lat; logic [31:0] rd; logic er, after;
    @(negedge clk);
    valid0 = 1'b1; addr0 = 32'h14;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (dut.state !== S_EXPAND) begin n_fail++; $display("FAIL rstmid_in_expand: got %0d expected 2", dut.state); end
    reset = 1'b1;
    #1;
    n_checks++; if (ready0 !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 0", ready0); end
    n_checks++; if (sraw0 !== 32'd0 || sdict0 !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_stats: got raw %h dict %h expected 0 and 0", sraw0, sdict0);
    end
    n_checks++; if (dut.state !== S_IDLE) begin n_fail++; $display("FAIL rstmid_state: got %0d expected 0", dut.state); end
    @(negedge clk);
    reset = 1'b0; valid0 = 1'b0;
    do_fetch(0, 32'h10, lat, rd, er, after);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rstmid_next_latency: got %0d expected 2", lat); end
    n_checks++; if (rd !== 32'h0000_0513) begin n_fail++; $display("FAIL rstmid_next_rdata: got %h expected 00000513", rd); end
    n_checks++; if (sraw0 !== 32'd1) begin n_fail++; $display("FAIL rstmid_next_stat: got %h expected 1", sraw0); end
  endtask

  // Scoreboard: model value and latency queued per request, popped per strobe.
  task automatic push_req(input int idx, inout int n_raw, inout int n_dict);
    if (ref_entry[idx][32]) begin
      exp_q.push_back(ref_dict[ref_entry[idx][2:0]]);
      exp_lat_q.push_back(3);
      n_dict++;
    end else begin
      exp_q.push_back(ref_entry[idx][31:0]);
      exp_lat_q.push_back(2);
      n_raw++;
    end
    addr0 = 32'(idx) << 2;
  endtask

  task automatic test_back_to_back;
    int n_raw, n_dict, lat, cnt, exp_lat;
    logic [31:0] exp_w;
    n_raw = 0; n_dict = 0; cnt = 0;
    for (int j = 0; j < 8; j++) begin
      ref_dict[j] = 32'hC0DE_0000 | (32'(j) * 32'h0001_0101);
      dut.dict_mem.mem[j] = ref_dict[j];
    end
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 0) ref_entry[i] = 33'h1_5A00_0000 | 33'(i % 8);
      else            ref_entry[i] = {1'b0, 32'h1000_0000 + 32'(i) * 32'h111};
      dut.entry_mem.mem[i] = ref_entry[i];
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    valid0 = 1'b1;
    push_req($urandom_range(0, 15), n_raw, n_dict);
    lat = 0;
    while (cnt < 100) begin
      @(negedge clk);
      lat++;
      if (ready0) begin
        exp_w   = exp_q.pop_front();
        exp_lat = exp_lat_q.pop_front();
        n_checks++; if (rdata0 !== exp_w) begin n_fail++; $display("FAIL b2b_rdata[%0d]: got %h expected %h", cnt, rdata0, exp_w); end
        n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", cnt, lat, exp_lat); end
        cnt++;
        if (cnt < 100) push_req($urandom_range(0, 15), n_raw, n_dict);
        else valid0 = 1'b0;
        lat = -1;
      end else if (lat > 20) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_timeout[%0d]: got no ready expected ready within 20 cycles", cnt);
        valid0 = 1'b0;
        break;
      end
    end
    @(negedge clk);
    n_checks++; if (sraw0 !== 32'(n_raw)) begin n_fail++; $display("FAIL b2b_stat_raw: got %0d expected %0d", sraw0, n_raw); end
    n_checks++; if (sdict0 !== 32'(n_dict)) begin n_fail++; $display("FAIL b2b_stat_dict: got %0d expected %0d", sdict0, n_dict); end
    n_checks++; if (sraw0 + sdict0 !== 32'd100) begin n_fail++; $display("FAIL b2b_stat_total: got %0d expected 100", sraw0 + sdict0); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1;
    valid0 = 1'b0; addr0 = '0;
    valid4 = 1'b0; addr4 = '0;
    load_basic();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_raw();
    test_dict();
    test_extra_lat();
    test_err();
    test_abort();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
